// File: rtl/beta_mem_pkg.sv
// Shared types and address helpers for the Beta main-memory arbiter.
// Memory words are 4 bytes wide. A byte address is in range when no bit above the word index is set.
package beta_mem_pkg;

    localparam int DEFAULT_MEM_AW = 16;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_I    = 2'd1,
        PORT_D    = 2'd2
    } port_id_t;

    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return addr >> 2;
    endfunction

    function automatic logic in_range(input logic [31:0] addr, input int aw);
        return (addr >> (aw + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/beta_mem_starve_ctr.sv
// Counts consecutive cycles in which a pending fetch is refused.
// The count saturates at STARVE_LIMIT, and at_limit_o then lets the fetch win.
module beta_mem_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic gnt_i,
    output logic at_limit_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] cnt_q, cnt_d;

    // NOTE: assign a default before any branch so the combinational block cannot infer a latch.
    always_comb begin
        cnt_d = 4'd0;
        if (req_i && !gnt_i) begin
            cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/beta_mem_arbiter.sv
// Lets the Beta fetch port and data port share one single-ported, synchronous-read memory.
// The data port has priority. A starvation guard bounds fetch latency. Read data goes back one cycle after the grant.
module beta_mem_arbiter
    import beta_mem_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int MEM_AW       = DEFAULT_MEM_AW,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic i_oor, d_oor, starved, pick_i, pick_d;

    assign i_oor = !in_range(i_addr, MEM_AW);
    assign d_oor = !in_range(d_addr, MEM_AW);

    beta_mem_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk       (clk),
        .rst       (rst),
        .req_i     (i_req),
        .gnt_i     (i_gnt),
        .at_limit_o(starved)
    );

    // The fetch port wins only when it is alone or when it has waited the limit.
    assign pick_i = i_req && (!d_req || starved);
    assign pick_d = d_req && !pick_i;

    assign i_gnt     = pick_i && !rst;
    assign d_gnt     = pick_d && !rst;
    assign d_err     = d_gnt && d_oor;
    assign mem_en    = (i_gnt && !i_oor) || (d_gnt && !d_oor);
    assign mem_we    = d_gnt && d_we && !d_oor;
    assign mem_addr  = pick_d ? MEM_AW'(word_addr(d_addr)) : MEM_AW'(word_addr(i_addr));
    assign mem_wdata = d_wdata;

    port_id_t          rd_owner_q, rd_owner_d;
    logic              rd_oor_q, rd_oor_d;
    logic [DATA_W-1:0] i_rdata_q, d_rdata_q, rd_fresh;

    always_comb begin
        rd_owner_d = PORT_NONE;
        rd_oor_d   = 1'b0;
        if (i_gnt) begin
            rd_owner_d = PORT_I;
            rd_oor_d   = i_oor;
        end else if (d_gnt && !d_we) begin
            rd_owner_d = PORT_D;
            rd_oor_d   = d_oor;
        end
    end

    // An out-of-range read never touched memory, so it returns zero.
    assign rd_fresh = rd_oor_q ? '0 : mem_rdata;
    assign i_rvalid = !rst && (rd_owner_q == PORT_I);
    assign d_rvalid = !rst && (rd_owner_q == PORT_D);
    assign i_rdata  = i_rvalid ? rd_fresh : i_rdata_q;
    assign d_rdata  = d_rvalid ? rd_fresh : d_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner_q <= PORT_NONE;
            rd_oor_q   <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            rd_owner_q <= rd_owner_d;
            rd_oor_q   <= rd_oor_d;
            if (i_rvalid) i_rdata_q <= rd_fresh;
            if (d_rvalid) d_rdata_q <= rd_fresh;
        end
    end

endmodule
